maxpool_spike_writeback: RTL and testbench

Downstream stage of the spiking max-pool unit. Consumes the pooled spike-row stream (valid/data/done, with ready backpressure) and writes each pooled row, channel-major and contiguous, into the feature-map spike SRAM for the next conv layer. Contains a small elastic FIFO to absorb the pool unit's in-flight rows and arbitration stalls on the SRAM write port. Signals layer completion and flags protocol errors.

---
 rtl/maxpool_spike_writeback_pkg.sv | 23 ++
 rtl/maxpool_spike_writeback_fifo.sv | 67 ++++++
 rtl/maxpool_spike_writeback.sv | 166 ++++++++++++++++
 tb/tb_maxpool_spike_writeback.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/maxpool_spike_writeback_pkg.sv
// Shared definitions for the max-pool spike writeback stage: spike-row
// width derivation, counter widths and the controller state encoding.
package maxpool_spike_writeback_pkg;

  localparam int IMG_WIDTH   = 8;
  localparam int TIME_STEPS  = 4;
  localparam int SPIKE_ROW_W = IMG_WIDTH * TIME_STEPS;
  localparam int TOTAL_W     = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } wb_state_e;

  // Pooling halves the row count; an odd trailing row is discarded.
  function automatic logic [15:0] pooled_rows(input logic [15:0] img_size);
    return img_size >> 1;
  endfunction

endpackage

// File: rtl/maxpool_spike_writeback_fifo.sv
// Small elastic FIFO between the pool unit and the SRAM write port.
// The head entry is presented straight from storage flops (first-word
// fall-through). A push while full is accepted only together with a pop.
module writeback_sync_fifo #(
  parameter  int DATA_W     = 32,
  parameter  int FIFO_DEPTH = 4,
  localparam int AW         = $clog2(FIFO_DEPTH),
  localparam int CW         = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // Next storage, pointers and occupancy from the qualified push/pop.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  // Storage and pointer registers; reset empties the buffer and zeroes data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/maxpool_spike_writeback.sv
// Writes the pooled spike-row stream channel-major and contiguous into the
// feature-map SRAM, absorbing in-flight rows and write-port stalls in a
// small FIFO, and reports layer completion and protocol errors.
module maxpool_spike_writeback
  import maxpool_spike_writeback_pkg::*;
#(
  parameter int DATA_W     = SPIKE_ROW_W,
  parameter int ADDR_W     = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              s_clk,
  input  logic              s_rst,
  input  logic              code_valid,
  input  logic [15:0]       conv_in_ch,
  input  logic [15:0]       conv_img_size,
  input  logic [ADDR_W-1:0] wr_base_addr,
  input  logic              i_pool_valid,
  input  logic [DATA_W-1:0] i_pool_spikes,
  input  logic              i_pool_done,
  output logic              o_pool_ready,
  output logic              o_ram_wr_en,
  output logic [ADDR_W-1:0] o_ram_wr_addr,
  output logic [DATA_W-1:0] o_ram_wr_data,
  input  logic              i_ram_wr_grant,
  output logic              o_layer_done,
  output logic              o_busy,
  output logic              o_err_overrun,
  output logic              o_err_short
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  wb_state_e          state_q, state_d;
  logic [15:0]        ch_q, ch_d;
  logic [15:0]        rows_q, rows_d;
  logic [TOTAL_W-1:0] total_q, total_d;
  logic [TOTAL_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [ADDR_W-1:0]  addr_ptr_q, addr_ptr_d;
  logic               ready_q, ready_d;
  logic               err_overrun_q, err_overrun_d;
  logic               err_short_q, err_short_d;

  logic               fifo_push, fifo_pop;
  logic [DATA_W-1:0]  fifo_dout;
  logic [CW-1:0]      fifo_count, count_next;
  logic               fifo_full, fifo_empty;

  writeback_sync_fifo #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (s_clk),
    .rst  (s_rst),
    .push (fifo_push),
    .pop  (fifo_pop),
    .din  (i_pool_spikes),
    .dout (fifo_dout),
    .count(fifo_count),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign o_ram_wr_en   = !fifo_empty;
  assign o_ram_wr_addr = addr_ptr_q;
  assign o_ram_wr_data = fifo_dout;
  assign o_pool_ready  = ready_q;
  assign o_layer_done  = (state_q == ST_DONE);
  assign o_busy        = (state_q != ST_IDLE);
  assign o_err_overrun = err_overrun_q;
  assign o_err_short   = err_short_q;

  // Layer sequencing, FIFO push/pop decisions, counters and error flags.
  always_comb begin
    state_d       = state_q;
    ch_d          = ch_q;
    rows_d        = rows_q;
    total_d       = TOTAL_W'(ch_q) * TOTAL_W'(rows_q);
    rx_cnt_d      = rx_cnt_q;
    addr_ptr_d    = addr_ptr_q;
    err_overrun_d = err_overrun_q;
    err_short_d   = err_short_q;
    fifo_push     = 1'b0;
    fifo_pop      = !fifo_empty && i_ram_wr_grant;

    if (fifo_pop) begin
      addr_ptr_d = addr_ptr_q + ADDR_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (code_valid) begin
          ch_d          = conv_in_ch;
          rows_d        = pooled_rows(conv_img_size);
          addr_ptr_d    = wr_base_addr;
          rx_cnt_d      = '0;
          err_overrun_d = 1'b0;
          err_short_d   = 1'b0;
          state_d       = ST_ARMED;
        end
      end
      ST_ARMED: begin
        state_d = (ch_q == '0 || rows_q == '0) ? ST_FLUSH : ST_RUN;
      end
      ST_RUN: begin
        if (rx_cnt_q == total_q) begin
          state_d = ST_FLUSH;
        end else begin
          if (i_pool_valid) begin
            if (!fifo_full || fifo_pop) begin
              fifo_push = 1'b1;
              rx_cnt_d  = rx_cnt_q + TOTAL_W'(1);
            end else begin
              err_overrun_d = 1'b1;
            end
          end
          if (i_pool_done) begin
            state_d = ST_FLUSH;
            if (rx_cnt_d < total_q) begin
              err_short_d = 1'b1;
            end
          end
        end
      end
      ST_FLUSH: begin
        if (fifo_empty) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    count_next = fifo_count + CW'(fifo_push) - CW'(fifo_pop);
    ready_d    = (state_d == ST_RUN) && (count_next <= CW'(FIFO_DEPTH - 3));
  end

  // Controller registers; reset abandons any layer in progress.
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      state_q       <= ST_IDLE;
      ch_q          <= '0;
      rows_q        <= '0;
      total_q       <= '0;
      rx_cnt_q      <= '0;
      addr_ptr_q    <= '0;
      ready_q       <= 1'b0;
      err_overrun_q <= 1'b0;
      err_short_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      ch_q          <= ch_d;
      rows_q        <= rows_d;
      total_q       <= total_d;
      rx_cnt_q      <= rx_cnt_d;
      addr_ptr_q    <= addr_ptr_d;
      ready_q       <= ready_d;
      err_overrun_q <= err_overrun_d;
      err_short_q   <= err_short_d;
    end
  end

endmodule

// File: tb/tb_maxpool_spike_writeback.sv
// Bench for maxpool_spike_writeback: table of layer scenarios with a write
// scoreboard, plus hand-written reset sequences.
module tb_maxpool_spike_writeback;

  localparam int DW = 32;
  localparam int AW = 12;

  logic          s_clk = 1'b0;
  logic          s_rst;
  logic          code_valid;
  logic [15:0]   conv_in_ch;
  logic [15:0]   conv_img_size;
  logic [AW-1:0] wr_base_addr;
  logic          i_pool_valid;
  logic [DW-1:0] i_pool_spikes;
  logic          i_pool_done;
  logic          o_pool_ready;
  logic          o_ram_wr_en;
  logic [AW-1:0] o_ram_wr_addr;
  logic [DW-1:0] o_ram_wr_data;
  logic          i_ram_wr_grant;
  logic          o_layer_done;
  logic          o_busy;
  logic          o_err_overrun;
  logic          o_err_short;

  typedef struct {
    logic [15:0] ch;
    logic [15:0] size;
    logic [11:0] base;
    int          beats;
    int          grantMode;
    bit          honorReady;
    bit          sendDone;
    int          expWrites;
    bit          expOverrun;
    bit          expShort;
    bit          expStall;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  vec_t vecs[8];
  exp_t sbQ[$];
  int   tests = 0;
  int   fails = 0;

  maxpool_spike_writeback #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .FIFO_DEPTH(4)
  ) dut (
    .s_clk         (s_clk),
    .s_rst         (s_rst),
    .code_valid    (code_valid),
    .conv_in_ch    (conv_in_ch),
    .conv_img_size (conv_img_size),
    .wr_base_addr  (wr_base_addr),
    .i_pool_valid  (i_pool_valid),
    .i_pool_spikes (i_pool_spikes),
    .i_pool_done   (i_pool_done),
    .o_pool_ready  (o_pool_ready),
    .o_ram_wr_en   (o_ram_wr_en),
    .o_ram_wr_addr (o_ram_wr_addr),
    .o_ram_wr_data (o_ram_wr_data),
    .i_ram_wr_grant(i_ram_wr_grant),
    .o_layer_done  (o_layer_done),
    .o_busy        (o_busy),
    .o_err_overrun (o_err_overrun),
    .o_err_short   (o_err_short)
  );

  // Free-running clock
  always #5 s_clk = ~s_clk;

  function automatic logic [DW-1:0] beatData(input int vi, input int idx);
    return {8'hA5, 8'(vi), 16'(idx * 257 + 16'h1234)};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ready"},   64'(o_pool_ready),  64'd0);
    checkOutput({tag, "_wr_en"},   64'(o_ram_wr_en),   64'd0);
    checkOutput({tag, "_wr_addr"}, 64'(o_ram_wr_addr), 64'd0);
    checkOutput({tag, "_wr_data"}, 64'(o_ram_wr_data), 64'd0);
    checkOutput({tag, "_done"},    64'(o_layer_done),  64'd0);
    checkOutput({tag, "_busy"},    64'(o_busy),        64'd0);
    checkOutput({tag, "_overrun"}, 64'(o_err_overrun), 64'd0);
    checkOutput({tag, "_short"},   64'(o_err_short),   64'd0);
  endtask

  task automatic idleInputs();
    code_valid     = 1'b0;
    i_pool_valid   = 1'b0;
    i_pool_done    = 1'b0;
    i_pool_spikes  = '0;
    i_ram_wr_grant = 1'b1;
  endtask

  // One full layer: config pulse at cycle 0, beats from cycle 2 (first RUN cycle)
  task automatic applyStimulus(input int vi, input vec_t v);
    int   sent = 0;
    int   nWrites = 0;
    int   lastWr = -1;
    int   doneCyc = -1;
    bit   doneSent = 1'b0;
    bit   holdPend = 1'b0;
    bit   stallSeen = 1'b0;
    logic [AW-1:0] holdAddr;
    logic [DW-1:0] holdData;
    exp_t e;
    sbQ.delete();
    conv_in_ch    = v.ch;
    conv_img_size = v.size;
    wr_base_addr  = v.base;
    for (int cyc = 0; cyc < 80 && doneCyc < 0; cyc++) begin
      @(posedge s_clk);
      #1;
      code_valid   = (cyc == 0);
      i_pool_valid = 1'b0;
      i_pool_done  = 1'b0;
      case (v.grantMode)
        1:       i_ram_wr_grant = (cyc % 2 == 0);
        2:       i_ram_wr_grant = (cyc >= 12);
        default: i_ram_wr_grant = 1'b1;
      endcase
      if (cyc >= 2 && sent < v.expWrites && !o_pool_ready) stallSeen = 1'b1;
      if (cyc >= 2 && sent < v.beats && (!v.honorReady || o_pool_ready)) begin
        i_pool_valid  = 1'b1;
        i_pool_spikes = beatData(vi, sent);
        if (sent < v.expWrites) begin
          e.addr = v.base + AW'(sent);
          e.data = beatData(vi, sent);
          sbQ.push_back(e);
        end
        sent++;
      end else if (v.sendDone && !doneSent && sent == v.beats && cyc >= 2) begin
        i_pool_done = 1'b1;
        doneSent    = 1'b1;
      end
      @(negedge s_clk);
      if (holdPend) begin
        checkOutput("hold_addr", 64'(o_ram_wr_addr), 64'(holdAddr));
        checkOutput("hold_data", 64'(o_ram_wr_data), 64'(holdData));
        holdPend = 1'b0;
      end
      if (o_ram_wr_en && i_ram_wr_grant) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpected_write", 64'(o_ram_wr_addr), 64'hFFFF_FFFF);
        end else begin
          e = sbQ.pop_front();
          checkOutput("wr_addr", 64'(o_ram_wr_addr), 64'(e.addr));
          checkOutput("wr_data", 64'(o_ram_wr_data), 64'(e.data));
        end
        nWrites++;
        lastWr = cyc;
      end else if (o_ram_wr_en) begin
        holdPend = 1'b1;
        holdAddr = o_ram_wr_addr;
        holdData = o_ram_wr_data;
      end
      if (cyc == 1) begin
        checkOutput("busy_armed",      64'(o_busy),        64'd1);
        checkOutput("overrun_cleared", 64'(o_err_overrun), 64'd0);
        checkOutput("short_cleared",   64'(o_err_short),   64'd0);
      end
      if (o_layer_done) doneCyc = cyc;
    end
    if (doneCyc < 0) checkOutput("done_timeout", 64'd0, 64'd1);
    else checkOutput("done_latency", 64'(doneCyc), (lastWr >= 0) ? 64'(lastWr + 2) : 64'd3);
    checkOutput("write_count",   64'(nWrites),       64'(v.expWrites));
    checkOutput("sb_leftover",   64'(sbQ.size()),    64'd0);
    checkOutput("err_overrun",   64'(o_err_overrun), 64'(v.expOverrun));
    checkOutput("err_short",     64'(o_err_short),   64'(v.expShort));
    checkOutput("ready_stalled", 64'(stallSeen),     64'(v.expStall));
    @(posedge s_clk);
    #1;
    idleInputs();
    @(negedge s_clk);
    checkOutput("done_one_cycle", 64'(o_layer_done), 64'd0);
    checkOutput("idle_not_busy",  64'(o_busy),       64'd0);
  endtask

  // Reset after three writes of a normal layer; nothing may survive it
  task automatic resetMidStream();
    int   sent = 0;
    int   nWrites = 0;
    int   doneSeen = 0;
    exp_t e;
    sbQ.delete();
    conv_in_ch    = 16'd2;
    conv_img_size = 16'd8;
    wr_base_addr  = 12'h100;
    for (int cyc = 0; cyc < 40 && nWrites < 3; cyc++) begin
      @(posedge s_clk);
      #1;
      code_valid     = (cyc == 0);
      i_pool_valid   = 1'b0;
      i_ram_wr_grant = 1'b1;
      if (cyc >= 2 && sent < 8 && o_pool_ready) begin
        i_pool_valid  = 1'b1;
        i_pool_spikes = beatData(20, sent);
        e.addr = 12'h100 + AW'(sent);
        e.data = beatData(20, sent);
        sbQ.push_back(e);
        sent++;
      end
      @(negedge s_clk);
      if (o_ram_wr_en && i_ram_wr_grant) begin
        e = sbQ.pop_front();
        checkOutput("rst_seq_wr_addr", 64'(o_ram_wr_addr), 64'(e.addr));
        nWrites++;
      end
    end
    checkOutput("rst_seq_writes", 64'(nWrites), 64'd3);
    s_rst = 1'b1;
    #1;
    checkResetValues("midrst");
    @(posedge s_clk);
    #1;
    idleInputs();
    @(posedge s_clk);
    #1;
    s_rst = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge s_clk);
      if (o_layer_done) doneSeen++;
    end
    checkOutput("no_done_after_reset", 64'(doneSeen), 64'd0);
    checkOutput("idle_after_reset",    64'(o_busy),   64'd0);
  endtask

  initial begin
    //          ch     size   base     beats gm honor done exp ovr shrt stall
    vecs[0] = '{16'd2, 16'd8, 12'h100, 8, 0, 1'b1, 1'b0, 8, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'd2, 16'd8, 12'h100, 8, 1, 1'b1, 1'b0, 8, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{16'd2, 16'd8, 12'h200, 6, 2, 1'b0, 1'b1, 4, 1'b1, 1'b1, 1'b1};
    vecs[3] = '{16'd1, 16'd8, 12'h300, 2, 0, 1'b1, 1'b1, 2, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{16'd1, 16'd8, 12'hFFE, 4, 0, 1'b1, 1'b0, 4, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{16'd0, 16'd8, 12'h040, 0, 0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{16'd1, 16'd8, 12'h050, 6, 0, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{16'd4, 16'd1, 12'h060, 0, 0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0};

    s_rst         = 1'b1;
    conv_in_ch    = '0;
    conv_img_size = '0;
    wr_base_addr  = '0;
    idleInputs();
    @(posedge s_clk);
    @(posedge s_clk);
    #1;
    checkResetValues("por");
    s_rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      $display("[TB] scenario %0d", i);
      applyStimulus(i, vecs[i]);
    end

    $display("[TB] reset mid-stream");
    resetMidStream();
    applyStimulus(9, vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
